// File: rtl/button_conditioner.sv
// button_conditioner: front end for the board push-buttons.
// Each raw pad is synchronized (2 flops), debounced by a 4-state FSM with a
// hold counter, and edge-detected into one-cycle press/release pulses.
// Accepted presses drive a latched one-hot (or all-zero) speed selection
// consumed by led_cycle.
// Optional build macro: BTN_REPEAT_EN adds per-button auto-repeat press
// pulses while a button stays held; these never touch speed_sel.
// Handshake: none; btn_press/btn_release are single-cycle strobes that are
// valid for exactly the cycle they are high, with no back-pressure.
module button_conditioner #(
   parameter int NUM_BTN         = 5,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_BTN-1:0]     btn_raw,
   output logic [NUM_BTN-1:0]     btn_level,
   output logic [NUM_BTN-1:0]     btn_press,
   output logic [NUM_BTN-1:0]     btn_release,
   output logic [NUM_BTN-1:0]     speed_sel,
   output logic [2*NUM_BTN-1:0]   dbg_state
);

   // Debounce counter sized to hold DEBOUNCE_CYCLES.
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The counter value at which the new level has been stable long enough.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Parameter sanity: debounce below 2 cycles or zero repeat timing is
   // meaningless; the block is empty and only documents the legal range.
   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_range
   end

   typedef enum logic [1:0] {
      ST_LOW  = 2'd0,
      ST_RISE = 2'd1,
      ST_HIGH = 2'd2,
      ST_FALL = 2'd3
   } state_t;

   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;

   state_t             r_state     [NUM_BTN];
   state_t             w_state_nxt [NUM_BTN];
   logic [CW-1:0]      r_cnt       [NUM_BTN];
   logic [CW-1:0]      w_cnt_nxt   [NUM_BTN];

   logic [NUM_BTN-1:0] r_press;
   logic [NUM_BTN-1:0] r_release;
   logic [NUM_BTN-1:0] w_press_nxt;
   logic [NUM_BTN-1:0] w_release_nxt;

   logic [NUM_BTN-1:0] r_speed_sel;
   logic [NUM_BTN-1:0] w_sel_nxt;
   logic               w_sel_found;

   // Two-flop synchronizer; r_sync2 is the only copy the FSMs look at.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce FSM state, counters and registered edge pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            r_state[i] <= ST_LOW;
            r_cnt[i]   <= '0;
         end
         r_press   <= '0;
         r_release <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_cnt[i]   <= w_cnt_nxt[i];
         end
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   // Debounce next-state: a new level must persist DEBOUNCE_CYCLES cycles
   // (counted from the synchronized edge) before it is accepted.
   always_comb begin
      w_press_nxt   = '0;
      w_release_nxt = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         w_state_nxt[i] = r_state[i];
         w_cnt_nxt[i]   = r_cnt[i];
         case (r_state[i])
            ST_LOW: begin
               if (r_sync2[i]) begin
                  w_state_nxt[i] = ST_RISE;
                  w_cnt_nxt[i]   = '0;
               end
            end
            ST_RISE: begin
               if (!r_sync2[i]) begin
                  // Bounce: drop back without any visible effect.
                  w_state_nxt[i] = ST_LOW;
                  w_cnt_nxt[i]   = '0;
               end else if ((r_cnt[i] + CW'(1)) == CNT_LAST) begin
                  w_state_nxt[i] = ST_HIGH;
                  w_cnt_nxt[i]   = '0;
                  w_press_nxt[i] = 1'b1;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + CW'(1);
               end
            end
            ST_HIGH: begin
               if (!r_sync2[i]) begin
                  w_state_nxt[i] = ST_FALL;
                  w_cnt_nxt[i]   = '0;
               end
            end
            ST_FALL: begin
               if (r_sync2[i]) begin
                  // Bounce while releasing: still considered held.
                  w_state_nxt[i] = ST_HIGH;
                  w_cnt_nxt[i]   = '0;
               end else if ((r_cnt[i] + CW'(1)) == CNT_LAST) begin
                  w_state_nxt[i]   = ST_LOW;
                  w_cnt_nxt[i]     = '0;
                  w_release_nxt[i] = 1'b1;
               end else begin
                  w_cnt_nxt[i] = r_cnt[i] + CW'(1);
               end
            end
            default: begin
               w_state_nxt[i] = ST_LOW;
               w_cnt_nxt[i]   = '0;
            end
         endcase
      end
   end

   // Debounced level and FSM debug view; level stays high through FALL
   // until the release is accepted.
   always_comb begin
      btn_level = '0;
      dbg_state = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         btn_level[i]         = (r_state[i] == ST_HIGH) || (r_state[i] == ST_FALL);
         dbg_state[2*i +: 2]  = r_state[i];
      end
   end

   // Speed selection next value: lowest-index real press wins; pressing the
   // currently selected button toggles the selection off.
   always_comb begin
      w_sel_nxt   = r_speed_sel;
      w_sel_found = 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (r_press[i] && !w_sel_found) begin
            w_sel_found = 1'b1;
            if (r_speed_sel == (NUM_BTN'(1) << i)) begin
               w_sel_nxt = '0;
            end else begin
               w_sel_nxt = NUM_BTN'(1) << i;
            end
         end
      end
   end

   // Speed selection register, updated the cycle after a press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_speed_sel <= '0;
      end else begin
         r_speed_sel <= w_sel_nxt;
      end
   end

   assign speed_sel   = r_speed_sel;
   assign btn_release = r_release;

`ifdef BTN_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(REP_MAX + 1);
   localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD);

   logic [RW-1:0]      r_rep_cnt [NUM_BTN];
   logic [NUM_BTN-1:0] r_rep_armed;
   logic [NUM_BTN-1:0] r_rep_pulse;

   // Auto-repeat: while a button remains in HIGH, emit an extra press after
   // REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles. The pulses
   // are kept apart from r_press so they never change speed_sel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            r_rep_cnt[i] <= '0;
         end
         r_rep_armed <= '0;
         r_rep_pulse <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if ((r_state[i] == ST_HIGH) && (w_state_nxt[i] == ST_HIGH)) begin
               if ((r_rep_cnt[i] + RW'(1)) == (r_rep_armed[i] ? REP_NEXT : REP_FIRST)) begin
                  r_rep_cnt[i]   <= '0;
                  r_rep_armed[i] <= 1'b1;
                  r_rep_pulse[i] <= 1'b1;
               end else begin
                  r_rep_cnt[i]   <= r_rep_cnt[i] + RW'(1);
                  r_rep_pulse[i] <= 1'b0;
               end
            end else begin
               r_rep_cnt[i]   <= '0;
               r_rep_armed[i] <= 1'b0;
               r_rep_pulse[i] <= 1'b0;
            end
         end
      end
   end

   assign btn_press = r_press | r_rep_pulse;
`else
   assign btn_press = r_press;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios for button_conditioner with a
// scoreboard. Stimulus pushes expected output events (kind, value, cycle)
// into exp_q; a monitor on the falling edge pops and compares every
// press/release pulse and every level or speed_sel change it observes.
module tb_button_conditioner;
  localparam int NB = 5;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int EW = 2 + NB + 32;

  localparam logic [1:0] K_PRESS = 2'd0;
  localparam logic [1:0] K_REL   = 2'd1;
  localparam logic [1:0] K_LEVEL = 2'd2;
  localparam logic [1:0] K_SPEED = 2'd3;

`ifdef BTN_REPEAT_EN
  localparam int HOLD60_REPS = 5;
`else
  localparam int HOLD60_REPS = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NB-1:0]   btn_raw = '0;
  logic [NB-1:0]   btn_level;
  logic [NB-1:0]   btn_press;
  logic [NB-1:0]   btn_release;
  logic [NB-1:0]   speed_sel;
  logic [2*NB-1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [NB-1:0] prev_level = '0;
  logic [NB-1:0] prev_speed = '0;

  button_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .speed_sel(speed_sel),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [NB-1:0] val, input int at);
    logic [31:0] at_v;
    at_v = at;
    exp_q.push_back({kind, val, at_v});
  endtask

  task automatic check_eq(input string name, input logic [NB-1:0] act, input logic [NB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard compare of one observed event against the queue head
  task automatic check_obs(input logic [1:0] kind, input logic [NB-1:0] val);
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    logic [31:0]   c;
    c = cyc;
    obs = {kind, val, c};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d value=%b cycle=%0d, required no event",
               kind, val, c);
    end else begin
      exp = exp_q.pop_front();
      if (exp !== obs) begin
        errors++;
        $display("FAIL event_kind%0d: got kind=%0d value=%b cycle=%0d, required kind=%0d value=%b cycle=%0d",
                 exp[EW-1 -: 2], kind, val, c, exp[EW-1 -: 2], exp[32 +: NB], exp[31:0]);
      end
    end
  endtask

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    if (btn_press !== '0) check_obs(K_PRESS, btn_press);
    if (btn_release !== '0) check_obs(K_REL, btn_release);
    if (btn_level !== prev_level) begin
      check_obs(K_LEVEL, btn_level);
      prev_level = btn_level;
    end
    if (speed_sel !== prev_speed) begin
      check_obs(K_SPEED, speed_sel);
      prev_speed = speed_sel;
    end
  end

  // driver: press mask, hold, release; pushes all expected events in order
  task automatic press_hold(input logic [NB-1:0] mask, input logic [NB-1:0] new_speed,
                            input int hold, input int n_rep);
    int t;
    t = cyc;
    btn_raw = mask;
    expect_ev(K_PRESS, mask, t + 6);
    expect_ev(K_LEVEL, mask, t + 6);
    expect_ev(K_SPEED, new_speed, t + 7);
    for (int k = 0; k < n_rep; k++) begin
      expect_ev(K_PRESS, mask, t + 6 + RD + k * RP);
    end
    wait_cycles(hold);
    t = cyc;
    btn_raw = '0;
    expect_ev(K_REL, mask, t + 6);
    expect_ev(K_LEVEL, '0, t + 6);
    wait_cycles(10);
  endtask

  initial begin
    int t;
    int guard;
    // reset with all buttons held
    btn_raw = '1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    wait_cycles(2);
    check_eq("reset_level", btn_level, '0);
    check_eq("reset_press", btn_press, '0);
    check_eq("reset_release", btn_release, '0);
    check_eq("reset_speed", speed_sel, '0);
    t = cyc;
    rst_n = 1'b1;
    expect_ev(K_PRESS, 5'b11111, t + 6);
    expect_ev(K_LEVEL, 5'b11111, t + 6);
    expect_ev(K_SPEED, 5'b00001, t + 7);
    wait_cycles(10);
    t = cyc;
    btn_raw = '0;
    expect_ev(K_REL, 5'b11111, t + 6);
    expect_ev(K_LEVEL, 5'b00000, t + 6);
    wait_cycles(10);

    // clean press of bit 2
    press_hold(5'b00100, 5'b00100, 10, 0);
    check_eq("clean_speed_hold", speed_sel, 5'b00100);

    // bounce on bit 1: nothing must be accepted
    btn_raw[1] = 1'b1; wait_cycles(1);
    btn_raw[1] = 1'b0; wait_cycles(1);
    btn_raw[1] = 1'b1; wait_cycles(1);
    btn_raw[1] = 1'b0; wait_cycles(12);
    check_eq("bounce_speed", speed_sel, 5'b00100);
    check_eq("bounce_level", btn_level, 5'b00000);

    // toggle on bit 3, then simultaneous bits 4 and 0
    press_hold(5'b01000, 5'b01000, 10, 0);
    press_hold(5'b01000, 5'b00000, 10, 0);
    press_hold(5'b10001, 5'b00001, 10, 0);

    // reset two cycles into RISE of bit 0, button kept held
    t = cyc;
    btn_raw[0] = 1'b1;
    wait_cycles(5);
    rst_n = 1'b0;
    expect_ev(K_SPEED, 5'b00000, cyc);
    wait_cycles(3);
    check_eq("midreset_level", btn_level, 5'b00000);
    t = cyc;
    rst_n = 1'b1;
    expect_ev(K_PRESS, 5'b00001, t + 6);
    expect_ev(K_LEVEL, 5'b00001, t + 6);
    expect_ev(K_SPEED, 5'b00001, t + 7);
    wait_cycles(10);
    t = cyc;
    btn_raw = '0;
    expect_ev(K_REL, 5'b00001, t + 6);
    expect_ev(K_LEVEL, 5'b00000, t + 6);
    wait_cycles(10);

    // long hold of bit 4 (auto-repeat when built with it)
    press_hold(5'b10000, 5'b10000, 60, HOLD60_REPS);
    check_eq("hold_speed", speed_sel, 5'b10000);

    // drain the scoreboard with a bounded wait
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      wait_cycles(1);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events still expected, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
